data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, accept-to-response cycles, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  CPU accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load result, extended to 32 bits.
REQ-014 SHALL have port resp_error  output  1  request was misaligned, out of range or illegal.
REQ-015 SHALL have port initial_values  input  32 x DEPTH  contents loaded on reset.
REQ-016 SHALL have port mem_check  output  32 x DEPTH  continuous view of every word, for benches.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with at most one request outstanding.
REQ-018 SHALL drive req_ready = 1 only in IDLE, decoded combinationally from state.
REQ-019 SHALL accept a request on a rising edge with req_valid && req_ready, latching write, addr, funct3 and wdata.
- Later changes on the req_* inputs have no effect.
REQ-020 SHALL, on accept, enter WAIT with counter = LATENCY-1, or enter RESP directly when LATENCY = 1.
REQ-021 SHALL decrement the counter each edge in WAIT and enter RESP on the edge where it is 0.
- Net effect: request accepted at edge N gives resp_valid = 1 after edge N+LATENCY.
REQ-022 SHALL perform the access (memory read, or store commit) on the edge that enters RESP.
REQ-023 SHALL hold resp_valid = 1, resp_rdata and resp_error stable in RESP until resp_ready = 1 on a rising edge, then return to IDLE.
- resp_valid = 0, resp_rdata = 0 and resp_error = 0 when not in RESP.
REQ-024 SHALL ignore req_valid outside IDLE; a new request is accepted no earlier than the edge after the response handshake.
REQ-025 SHALL index words by addr[1+log2(DEPTH):2] and use little-endian byte lanes.
REQ-026 SHALL flag an error for any of:
- addr >= 4*DEPTH;
- H/HU with addr[0] = 1;
- W with addr[1:0] != 0;
- load funct3 in {011, 110, 111};
- store funct3 other than 000/001/010.
REQ-027 SHALL, on error, write no memory and return resp_rdata = 0, resp_error = 1.
REQ-028 SHALL return loads as follows:
- LB: selected byte, sign-extended;
- LBU: selected byte, zero-extended;
- LH: half at addr[1], sign-extended;
- LHU: half at addr[1], zero-extended;
- LW: full word.
REQ-029 SHALL write only the addressed lanes on SB/SH/SW (low byte, low half or full word of wdata), preserving the other bytes, and return resp_rdata = 0.
REQ-030 SHALL keep mem_check equal to the current memory contents, with a store visible after its commit edge.

Reset
REQ-031 SHALL, while reset = 1 and independent of clk, hold:
- every word[i] = initial_values[i];
- state IDLE, counter 0;
- resp_valid = 0, resp_rdata = 0, resp_error = 0, req_ready = 1.
REQ-032 SHALL abort any pending request on reset, including an uncommitted store in WAIT; no write occurs and no response is produced afterwards.

Verification
REQ-033 SHALL pass: initial_values[i] = 3000+i, LATENCY 2, LW addr 0x08 accepted at edge N -> resp_valid after edge N+2, rdata 3002, error 0.
REQ-034 SHALL pass: word3 = 0x11223344, SB addr 0x0D wdata 0x000000AB -> mem_check[3] = 0x1122AB44; then LBU 0x0D -> 0x000000AB; LB 0x0D -> 0xFFFFFFAB; LHU 0x0E -> 0x00001122.
REQ-035 SHALL pass: LH addr 0x03 -> error 1, rdata 0; SW addr 0x80 with DEPTH 32 -> error 1, mem_check unchanged.
REQ-036 SHALL pass: LW response with resp_ready = 0 for 5 cycles and req_valid = 1 throughout -> resp_valid, rdata and error stable; req_ready = 0; no second accept until the edge after resp_ready = 1.
REQ-037 SHALL pass: LATENCY 1, LW addr 0x04 -> resp_valid after the next edge, rdata 3001.
REQ-038 SHALL pass: SW addr 0x10 wdata 0xDEADBEEF, reset pulsed mid-clock while in WAIT -> mem_check[4] = 3004, resp_valid 0, req_ready 1.

Source files
------------

// File: rtl/data_memory.sv
// Word-organised data memory serving one RV32I load/store at a time with a fixed
// accept-to-response latency and a valid/ready handshake on both sides.
module data_memory #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    input  logic [DEPTH-1:0][31:0] initial_values,
    output logic [DEPTH-1:0][31:0] mem_check
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_count, w_count_next;
    logic        r_write;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_error;

    logic        w_accept, w_enter_resp;
    logic        w_write;
    logic [31:0] w_addr, w_wdata;
    logic [2:0]  w_funct3;
    logic [AW-1:0] w_idx;
    logic        w_oor, w_mis, w_illegal, w_error;
    logic [31:0] w_word, w_load, w_merged, w_wlanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (LATENCY == 1) begin
                    w_state_next = S_RESP;
                    w_count_next = 4'd0;
                end else begin
                    w_state_next = S_WAIT;
                    w_count_next = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (r_count == 4'd0) w_state_next = S_RESP;
                else                 w_count_next = r_count - 4'd1;
            end
            S_RESP: if (resp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // With LATENCY 1 the access happens on the accept edge, so use the live request
    assign w_write  = (r_state == S_IDLE) ? req_write  : r_write;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_idx  = w_addr[AW+1:2];
    assign w_oor  = {1'b0, w_addr} >= 33'(4 * DEPTH);
    assign w_word = w_oor ? 32'd0 : r_mem[w_idx];

    always_comb begin
        w_mis     = 1'b0;
        w_illegal = 1'b0;
        case (w_funct3)
            3'b000: w_mis = 1'b0;
            3'b001: w_mis = w_addr[0];
            3'b010: w_mis = |w_addr[1:0];
            3'b100: w_illegal = w_write;
            3'b101: begin
                w_illegal = w_write;
                w_mis     = w_addr[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_error = w_oor || w_mis || w_illegal;

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so each lane picks its own slice
    always_comb begin
        case (w_funct3)
            3'b000: begin
                w_be     = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            3'b001: begin
                w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            3'b010: begin
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = w_wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = w_be[gi] ? w_wlanes[8*gi +: 8] : w_word[8*gi +: 8];
        end
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign mem_check[gi] = r_mem[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= initial_values[i];
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
            end
            if (w_enter_resp) begin
                r_error <= w_error;
                r_rdata <= (w_error || w_write) ? 32'd0 : w_load;
                if (!w_error && w_write) r_mem[w_idx] <= w_merged;
            end else if (r_state == S_RESP && resp_ready) begin
                r_rdata <= 32'd0;
                r_error <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_error = r_error;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: LATENCY 2 and LATENCY 1 instances run in lockstep against
// an array-based reference model of the RV32I load/store rules.
module tb_data_memory;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic [DEPTH-1:0][31:0] init_vals, mc2, mc1;
    logic        rdy2, vld2, err2, rdy1, vld1, err1;
    logic [31:0] rd2, rd1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;
    logic        last_err;

    data_memory #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .resp_valid(vld2), .resp_ready(resp_ready),
        .resp_rdata(rd2), .resp_error(err2), .initial_values(init_vals), .mem_check(mc2)
    );

    data_memory #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .resp_valid(vld1), .resp_ready(resp_ready),
        .resp_rdata(rd1), .resp_error(err1), .initial_values(init_vals), .mem_check(mc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd3000 + 32'(i);
    endfunction

    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] f,
                                  input logic [31:0] d, output logic [31:0] rd, output logic er);
        int unsigned off, idx;
        logic [31:0] word, b, h, mask;
        rd = 32'd0;
        er = 1'b0;
        off = a % 4;
        idx = a / 4;
        if (a >= 32'(4 * DEPTH)) er = 1'b1;
        if (w && !(f inside {3'd0, 3'd1, 3'd2})) er = 1'b1;
        if (!w && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
        if ((f == 3'd1 || f == 3'd5) && (a % 2) != 0) er = 1'b1;
        if (f == 3'd2 && off != 0) er = 1'b1;
        if (er) return;
        word = model_mem[idx];
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (w) begin
            case (f)
                3'd0: begin
                    mask = 32'hFF << (8 * off);
                    word = (word & ~mask) | ((d & 32'hFF) << (8 * off));
                end
                3'd1: begin
                    mask = 32'hFFFF << (16 * (off / 2));
                    word = (word & ~mask) | ((d & 32'hFFFF) << (16 * (off / 2)));
                end
                default: word = d;
            endcase
            model_mem[idx] = word;
        end else begin
            case (f)
                3'd0: rd = (b >= 128) ? b - 32'd256 : b;
                3'd4: rd = b;
                3'd1: rd = (h >= 32768) ? h - 32'd65536 : h;
                3'd5: rd = h;
                default: rd = word;
            endcase
        end
    endfunction

    task automatic compare_all_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check({tag, "_mem_l2"}, mc2[i], model_mem[i]);
            check({tag, "_mem_l1"}, mc1[i], model_mem[i]);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, input int hold, input bit keep_valid);
        logic [31:0] erd;
        logic eer;
        int idx;
        idx = int'(a >> 2);
        model(w, a, f, d, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f; req_wdata = d;
        resp_ready = 1'b0;
        check("req_ready_idle", {31'd0, rdy2}, 32'd1);
        @(posedge clk); #1;
        if (!keep_valid) req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
        check("l1_valid", {31'd0, vld1}, 32'd1);
        check("l1_rdata", rd1, erd);
        check("l1_error", {31'd0, err1}, {31'd0, eer});
        if (w && !eer) check("l1_commit", mc1[idx], model_mem[idx]);
        check("l2_valid_n", {31'd0, vld2}, 32'd0);
        check("l2_ready_busy", {31'd0, rdy2}, 32'd0);
        @(posedge clk); #1;
        check("l2_valid_n1", {31'd0, vld2}, 32'd0);
        @(posedge clk); #1;
        check("l2_valid_n2", {31'd0, vld2}, 32'd1);
        check("l2_rdata", rd2, erd);
        check("l2_error", {31'd0, err2}, {31'd0, eer});
        if (w && !eer) check("l2_commit", mc2[idx], model_mem[idx]);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, vld2}, 32'd1);
            check("hold_rdata", rd2, erd);
            check("hold_error", {31'd0, err2}, {31'd0, eer});
            check("hold_ready", {31'd0, rdy2}, 32'd0);
            check("hold_l1_valid", {31'd0, vld1}, 32'd1);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        last_rd = rd2;
        last_err = err2;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        check("done_valid", {31'd0, vld2}, 32'd0);
        check("done_rdata", rd2, 32'd0);
        check("done_ready", {31'd0, rdy2}, 32'd1);
        check("done_l1_valid", {31'd0, vld1}, 32'd0);
        compare_all_mem("txn");
        $display("txn w=%0d addr=%h f3=%0d wdata=%h -> rdata=%h err=%0d (exp %h/%0d)",
                 w, a, f, d, last_rd, last_err, erd, eer);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'd2;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_wait_state", {31'd0, rdy2}, 32'd0);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("rst_async_ready", {31'd0, rdy2}, 32'd1);
        check("rst_async_valid", {31'd0, vld2}, 32'd0);
        check("rst_async_mem4", mc2[4], 32'd3004);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rst_no_resp", {31'd0, vld2}, 32'd0);
            check("rst_no_resp_l1", {31'd0, vld1}, 32'd0);
            check("rst_mem4", mc2[4], 32'd3004);
        end
        compare_all_mem("rst");
        $display("txn reset pulsed in WAIT for SW 0x10 -> mem4=%h ready=%0d", mc2[4], rdy2);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) init_vals[i] = 32'd3000 + 32'(i);
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_ready", {31'd0, rdy2}, 32'd1);
        check("reset_valid", {31'd0, vld2}, 32'd0);
        check("reset_rdata", rd2, 32'd0);
        check("reset_error", {31'd0, err2}, 32'd0);
        compare_all_mem("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        do_req(1'b0, 32'h08, 3'd2, 32'd0, 0, 1'b0);
        check("lw_08", last_rd, 32'd3002);
        do_req(1'b0, 32'h04, 3'd2, 32'd0, 5, 1'b1);
        check("lw_04_hold", last_rd, 32'd3001);
        do_req(1'b1, 32'h0C, 3'd2, 32'h11223344, 0, 1'b0);
        do_req(1'b1, 32'h0D, 3'd0, 32'h000000AB, 1, 1'b0);
        check("sb_0d_mem3", mc2[3], 32'h1122AB44);
        do_req(1'b0, 32'h0D, 3'd4, 32'd0, 0, 1'b0);
        check("lbu_0d", last_rd, 32'h000000AB);
        do_req(1'b0, 32'h0D, 3'd0, 32'd0, 0, 1'b0);
        check("lb_0d", last_rd, 32'hFFFFFFAB);
        do_req(1'b0, 32'h0E, 3'd5, 32'd0, 0, 1'b0);
        check("lhu_0e", last_rd, 32'h00001122);
        do_req(1'b0, 32'h03, 3'd1, 32'd0, 0, 1'b0);
        check("lh_03_err", {31'd0, last_err}, 32'd1);
        check("lh_03_rdata", last_rd, 32'd0);
        do_req(1'b1, 32'h80, 3'd2, 32'h55AA55AA, 0, 1'b0);
        check("sw_80_err", {31'd0, last_err}, 32'd1);

        reset_in_wait();

        for (int t = 0; t < 150; t++) begin
            do_req(1'($urandom), 32'($urandom_range(0, 4 * DEPTH + 15)),
                   3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
